// File: rtl/pipe_ctrl_seq_pkg.sv
// rtl/pipe_ctrl_seq_pkg.sv - ISA widths, control-word field slices, opcodes and halt FSM states
package pipe_ctrl_seq_pkg;

    localparam int OPC_W = 5;
    localparam int RA_W  = 5;
    localparam int EX_W  = 15;
    localparam int MA_W  = 2;
    localparam int WB_W  = 3;

    // EX control word fields
    localparam int EX_ALU_LO   = 0;
    localparam int EX_ALU_HI   = 2;
    localparam int EX_ALUSRC   = 3;
    localparam int EX_SETFLAGS = 4;
    localparam int EX_BR_EN    = 5;
    localparam int EX_JMP_EN   = 6;
    localparam int EX_LINK     = 7;
    localparam int EX_COND_LO  = 8;
    localparam int EX_COND_HI  = 11;
    localparam int EX_NEED_RS1 = 12;
    localparam int EX_NEED_RS2 = 13;
    localparam int EX_STORE    = 14;

    // MA / WB control word fields
    localparam int MA_EN      = 0;
    localparam int MA_RW      = 1;
    localparam int WB_R_WE    = 0;
    localparam int WB_RDST_LO = 1;
    localparam int WB_RDST_HI = 2;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [1:0] RDST_ALU  = 2'b01;
    localparam logic [1:0] RDST_LINK = 2'b10;
    localparam logic [1:0] RDST_MEM  = 2'b11;

    // Immediate extension select driven to the ID stage
    localparam logic [1:0] SX_NONE  = 2'b00;
    localparam logic [1:0] SX_IMM16 = 2'b01;
    localparam logic [1:0] SX_OFF22 = 2'b10;
    localparam logic [1:0] SX_ZERO  = 2'b11;

    localparam logic [OPC_W-1:0] OP_NOP = 5'h00;
    localparam logic [OPC_W-1:0] OP_ADD = 5'h01;
    localparam logic [OPC_W-1:0] OP_SUB = 5'h02;
    localparam logic [OPC_W-1:0] OP_AND = 5'h03;
    localparam logic [OPC_W-1:0] OP_OR  = 5'h04;
    localparam logic [OPC_W-1:0] OP_XOR = 5'h05;
    localparam logic [OPC_W-1:0] OP_CMP = 5'h06;
    localparam logic [OPC_W-1:0] OP_LDX = 5'h08;
    localparam logic [OPC_W-1:0] OP_STX = 5'h09;
    localparam logic [OPC_W-1:0] OP_BR  = 5'h0C;
    localparam logic [OPC_W-1:0] OP_JMP = 5'h0D;
    localparam logic [OPC_W-1:0] OP_HLT = 5'h1F;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    function automatic logic is_load(input logic [MA_W-1:0] ma, input logic [WB_W-1:0] wb);
        return ma[MA_EN] && !ma[MA_RW] && wb[WB_R_WE];
    endfunction

endpackage

// File: rtl/pipe_ctrl_seq_ctrl_decode.sv
// rtl/pipe_ctrl_seq_ctrl_decode.sv - combinational ID decode into EX/MA/WB control words
module ctrl_decode
    import pipe_ctrl_seq_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic             bit16,
    input  logic [3:0]       cond_bits,
    output logic [1:0]       sign_ext,
    output logic             rs2_sel,
    output logic [EX_W-1:0]  ex_ctrl,
    output logic [MA_W-1:0]  ma_ctrl,
    output logic [WB_W-1:0]  wb_ctrl
);

    logic [2:0] alu_op;
    logic       logic_op;

    assign logic_op = (opcode == OP_AND) || (opcode == OP_OR) || (opcode == OP_XOR);

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_SUB, OP_CMP: alu_op = ALU_SUB;
            OP_AND:         alu_op = ALU_AND;
            OP_OR:          alu_op = ALU_OR;
            OP_XOR:         alu_op = ALU_XOR;
            default:        alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        sign_ext = SX_NONE;
        rs2_sel  = 1'b0;
        ex_ctrl  = '0;
        ma_ctrl  = '0;
        wb_ctrl  = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
                // bit16 selects the immediate form; logic ops zero-extend it
                ex_ctrl[EX_ALU_HI:EX_ALU_LO] = alu_op;
                ex_ctrl[EX_ALUSRC]           = bit16;
                ex_ctrl[EX_NEED_RS1]         = 1'b1;
                ex_ctrl[EX_NEED_RS2]         = !bit16;
                rs2_sel                      = bit16;
                if (bit16)
                    sign_ext = logic_op ? SX_ZERO : SX_IMM16;
                if (opcode == OP_CMP) begin
                    ex_ctrl[EX_SETFLAGS] = 1'b1;
                end else begin
                    wb_ctrl[WB_R_WE]               = 1'b1;
                    wb_ctrl[WB_RDST_HI:WB_RDST_LO] = RDST_ALU;
                end
            end
            OP_LDX: begin
                ex_ctrl[EX_ALU_HI:EX_ALU_LO]   = ALU_ADD;
                ex_ctrl[EX_ALUSRC]             = bit16;
                ex_ctrl[EX_NEED_RS1]           = 1'b1;
                ex_ctrl[EX_NEED_RS2]           = !bit16;
                rs2_sel                        = bit16;
                sign_ext                       = bit16 ? SX_IMM16 : SX_NONE;
                ma_ctrl[MA_EN]                 = 1'b1;
                wb_ctrl[WB_R_WE]               = 1'b1;
                wb_ctrl[WB_RDST_HI:WB_RDST_LO] = RDST_MEM;
            end
            OP_STX: begin
                ex_ctrl[EX_ALU_HI:EX_ALU_LO] = ALU_ADD;
                ex_ctrl[EX_ALUSRC]           = 1'b1;
                ex_ctrl[EX_NEED_RS1]         = 1'b1;
                ex_ctrl[EX_NEED_RS2]         = 1'b1;
                ex_ctrl[EX_STORE]            = 1'b1;
                rs2_sel                      = 1'b1;
                sign_ext                     = SX_IMM16;
                ma_ctrl[MA_EN]               = 1'b1;
                ma_ctrl[MA_RW]               = 1'b1;
            end
            OP_BR: begin
                ex_ctrl[EX_ALU_HI:EX_ALU_LO]   = ALU_ADD;
                ex_ctrl[EX_ALUSRC]             = 1'b1;
                ex_ctrl[EX_BR_EN]              = 1'b1;
                ex_ctrl[EX_COND_HI:EX_COND_LO] = cond_bits;
                rs2_sel                        = 1'b1;
                sign_ext                       = SX_OFF22;
            end
            OP_JMP: begin
                // bit16 on a jump requests a link write of the return address
                ex_ctrl[EX_ALU_HI:EX_ALU_LO] = ALU_ADD;
                ex_ctrl[EX_ALUSRC]           = 1'b1;
                ex_ctrl[EX_JMP_EN]           = 1'b1;
                ex_ctrl[EX_LINK]             = bit16;
                ex_ctrl[EX_NEED_RS1]         = 1'b1;
                rs2_sel                      = 1'b1;
                sign_ext                     = SX_IMM16;
                if (bit16) begin
                    wb_ctrl[WB_R_WE]               = 1'b1;
                    wb_ctrl[WB_RDST_HI:WB_RDST_LO] = RDST_LINK;
                end
            end
            default: begin
                sign_ext = SX_NONE;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_seq.sv
// rtl/pipe_ctrl_seq.sv - pipeline control registers, load-use interlock and halt-drain FSM
// Optional load-use interlock: PIPE_CTRL_LOADUSE_EN.
module pipe_ctrl_seq
    import pipe_ctrl_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [OPC_W-1:0] opcode,
    input  logic             bit16,
    input  logic [3:0]       cond_bits,
    input  logic [RA_W-1:0]  rs1_idx,
    input  logic [RA_W-1:0]  rs2_idx,
    input  logic [RA_W-1:0]  rd_idx,
    input  logic             stall_ext,
    input  logic             flush,
    output logic [1:0]       sign_ext,
    output logic             rs2_sel,
    output logic [EX_W-1:0]  ex_ctrl,
    output logic             ex_valid,
    output logic [MA_W-1:0]  ma_ctrl,
    output logic             ma_valid,
    output logic [WB_W-1:0]  wb_ctrl,
    output logic             wb_valid,
    output logic             stall_id,
    output logic             halt_fetch,
    output logic             halted
);

    logic [EX_W-1:0] dec_ex;
    logic [MA_W-1:0] dec_ma;
    logic [WB_W-1:0] dec_wb;

    // MA/WB words riding along in the ID/EX and EX/MA registers
    logic [MA_W-1:0] idex_ma;
    logic [WB_W-1:0] idex_wb;
    logic [WB_W-1:0] exma_wb;

    state_t state, state_next;
    logic   id_is_hlt;
    logic   load_real;

    ctrl_decode u_decode (
        .opcode    (opcode),
        .bit16     (bit16),
        .cond_bits (cond_bits),
        .sign_ext  (sign_ext),
        .rs2_sel   (rs2_sel),
        .ex_ctrl   (dec_ex),
        .ma_ctrl   (dec_ma),
        .wb_ctrl   (dec_wb)
    );

    assign id_is_hlt = valid_in && (opcode == OP_HLT);

`ifdef PIPE_CTRL_LOADUSE_EN
    logic [RA_W-1:0] ex_rd;
    logic            rd_hit;

    always_ff @(posedge clk) begin
        if (rst)
            ex_rd <= '0;
        else if (!stall_ext)
            ex_rd <= rd_idx;
    end

    assign rd_hit   = (dec_ex[EX_NEED_RS1] && (rs1_idx == ex_rd)) ||
                      (dec_ex[EX_NEED_RS2] && (rs2_idx == ex_rd));
    assign stall_id = ex_valid && is_load(idex_ma, idex_wb) && valid_in && rd_hit && !flush;
`else
    logic unused_hazard_inputs;

    assign unused_hazard_inputs = ^{rs1_idx, rs2_idx, rd_idx,
                                    dec_ex[EX_NEED_RS2:EX_NEED_RS1]};
    assign stall_id = 1'b0;
`endif

    // HLT never occupies a stage; it only moves the FSM into DRAIN
    assign load_real = (state == ST_RUN) && valid_in && !flush && !stall_id && !id_is_hlt;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (id_is_hlt && !flush && !stall_ext && !stall_id)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!stall_ext && !ex_valid && !ma_valid && !wb_valid)
                    state_next = ST_HALTED;
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // halt_fetch tracks the incoming state; halted follows the settled state
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_fetch <= 1'b0;
            halted     <= 1'b0;
        end else begin
            halt_fetch <= (state_next != ST_RUN);
            halted     <= (state == ST_HALTED);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl  <= '0;
            idex_ma  <= '0;
            idex_wb  <= '0;
            ex_valid <= 1'b0;
            ma_ctrl  <= '0;
            exma_wb  <= '0;
            ma_valid <= 1'b0;
            wb_ctrl  <= '0;
            wb_valid <= 1'b0;
        end else if (!stall_ext) begin
            ex_ctrl  <= load_real ? dec_ex : '0;
            idex_ma  <= load_real ? dec_ma : '0;
            idex_wb  <= load_real ? dec_wb : '0;
            ex_valid <= load_real;
            ma_ctrl  <= idex_ma;
            exma_wb  <= idex_wb;
            ma_valid <= ex_valid;
            wb_ctrl  <= exma_wb;
            wb_valid <= ma_valid;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// tb/tb_pipe_ctrl_seq.sv - directed self-checking bench for pipe_ctrl_seq
module tb_pipe_ctrl_seq;

    localparam logic [4:0] T_ADD = 5'h01;
    localparam logic [4:0] T_SUB = 5'h02;
    localparam logic [4:0] T_AND = 5'h03;
    localparam logic [4:0] T_LDX = 5'h08;
    localparam logic [4:0] T_BR  = 5'h0C;
    localparam logic [4:0] T_JMP = 5'h0D;
    localparam logic [4:0] T_HLT = 5'h1F;

    // Hand-derived control words
    localparam logic [14:0] EX_ADD_R  = 15'h3001;
    localparam logic [14:0] EX_SUB_R  = 15'h3002;
    localparam logic [14:0] EX_LDX_R  = 15'h3001;
    localparam logic [14:0] EX_LDX_I  = 15'h1009;
    localparam logic [14:0] EX_JMP_L  = 15'h10C9;
    localparam logic [14:0] EX_BR_A   = 15'h0A29;
    localparam logic [1:0]  MA_LOAD   = 2'b01;
    localparam logic [2:0]  WB_ALU    = 3'b011;
    localparam logic [2:0]  WB_MEM    = 3'b111;
    localparam logic [2:0]  WB_LINK   = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [4:0]  opcode;
    logic        bit16;
    logic [3:0]  cond_bits;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic        stall_ext;
    logic        flush;
    logic [1:0]  sign_ext;
    logic        rs2_sel;
    logic [14:0] ex_ctrl;
    logic        ex_valid;
    logic [1:0]  ma_ctrl;
    logic        ma_valid;
    logic [2:0]  wb_ctrl;
    logic        wb_valid;
    logic        stall_id;
    logic        halt_fetch;
    logic        halted;

    int checks = 0;
    int errors = 0;

    pipe_ctrl_seq dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .opcode     (opcode),
        .bit16      (bit16),
        .cond_bits  (cond_bits),
        .rs1_idx    (rs1_idx),
        .rs2_idx    (rs2_idx),
        .rd_idx     (rd_idx),
        .stall_ext  (stall_ext),
        .flush      (flush),
        .sign_ext   (sign_ext),
        .rs2_sel    (rs2_sel),
        .ex_ctrl    (ex_ctrl),
        .ex_valid   (ex_valid),
        .ma_ctrl    (ma_ctrl),
        .ma_valid   (ma_valid),
        .wb_ctrl    (wb_ctrl),
        .wb_valid   (wb_valid),
        .stall_id   (stall_id),
        .halt_fetch (halt_fetch),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic b16,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        valid_in = 1'b1;
        opcode   = op;
        bit16    = b16;
        rs1_idx  = r1;
        rs2_idx  = r2;
        rd_idx   = rd;
    endtask

    task automatic idle();
        valid_in = 1'b0;
        opcode   = 5'h00;
        bit16    = 1'b0;
        rs1_idx  = 5'd0;
        rs2_idx  = 5'd0;
        rd_idx   = 5'd0;
    endtask

    initial begin
        rst       = 1'b1;
        stall_ext = 1'b0;
        flush     = 1'b0;
        cond_bits = 4'h0;
        idle();
        step();
        step();
        chk("rst_ex_valid", {15'd0, ex_valid}, 16'd0);
        chk("rst_ex_ctrl", {1'b0, ex_ctrl}, 16'd0);
        chk("rst_ma_valid", {15'd0, ma_valid}, 16'd0);
        chk("rst_wb_valid", {15'd0, wb_valid}, 16'd0);
        chk("rst_halt_fetch", {15'd0, halt_fetch}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);

        // ADD r1,r2,r3 flowing through all stages
        rst = 1'b0;
        issue(T_ADD, 1'b0, 5'd2, 5'd3, 5'd1);
        #1;
        chk("add_sign_ext", {14'd0, sign_ext}, 16'd0);
        chk("add_rs2_sel", {15'd0, rs2_sel}, 16'd0);
        step();
        chk("add_ex_ctrl", {1'b0, ex_ctrl}, {1'b0, EX_ADD_R});
        chk("add_ex_valid", {15'd0, ex_valid}, 16'd1);
        idle();
        step();
        chk("add_ma_valid", {15'd0, ma_valid}, 16'd1);
        chk("add_ex_bubble", {15'd0, ex_valid}, 16'd0);
        step();
        chk("add_wb_ctrl", {13'd0, wb_ctrl}, {13'd0, WB_ALU});
        chk("add_wb_valid", {15'd0, wb_valid}, 16'd1);
        step();
        chk("add_wb_gone", {15'd0, wb_valid}, 16'd0);

        // Combinational ID selects for branch and logic-immediate forms
        cond_bits = 4'hA;
        opcode    = T_BR;
        #1;
        chk("br_sign_ext", {14'd0, sign_ext}, 16'd2);
        chk("br_rs2_sel", {15'd0, rs2_sel}, 16'd1);
        issue(T_BR, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        chk("br_ex_ctrl", {1'b0, ex_ctrl}, {1'b0, EX_BR_A});
        idle();
        opcode = T_AND;
        bit16  = 1'b1;
        #1;
        chk("andi_sign_ext", {14'd0, sign_ext}, 16'd3);
        idle();
        cond_bits = 4'h0;
        step();
        step();
        step();

        // Load-use interlock
        issue(T_LDX, 1'b0, 5'd4, 5'd5, 5'd3);
        step();
        chk("ldx_ex_ctrl", {1'b0, ex_ctrl}, {1'b0, EX_LDX_R});
        issue(T_LDX, 1'b1, 5'd8, 5'd3, 5'd9);
        #1;
        chk("lu_no_need_rs2", {15'd0, stall_id}, 16'd0);
        step();
        chk("ldxi_ex_ctrl", {1'b0, ex_ctrl}, {1'b0, EX_LDX_I});
        chk("ldx_ma_ctrl", {14'd0, ma_ctrl}, {14'd0, MA_LOAD});
        issue(T_ADD, 1'b0, 5'd9, 5'd6, 5'd7);
        flush = 1'b1;
        #1;
        chk("lu_flush_mask", {15'd0, stall_id}, 16'd0);
        flush = 1'b0;
        #1;
`ifdef PIPE_CTRL_LOADUSE_EN
        chk("lu_stall_id", {15'd0, stall_id}, 16'd1);
        step();
        chk("lu_bubble", {15'd0, ex_valid}, 16'd0);
        chk("lu_load_in_ma", {15'd0, ma_valid}, 16'd1);
        chk("lu_stall_drop", {15'd0, stall_id}, 16'd0);
        step();
        chk("lu_add_late", {15'd0, ex_valid}, 16'd1);
        chk("lu_add_ctrl", {1'b0, ex_ctrl}, {1'b0, EX_ADD_R});
`else
        chk("lu_stall_id", {15'd0, stall_id}, 16'd0);
        step();
        chk("lu_no_bubble", {15'd0, ex_valid}, 16'd1);
        chk("lu_add_ctrl", {1'b0, ex_ctrl}, {1'b0, EX_ADD_R});
`endif
        idle();
        step();
        step();
        step();

        // Flush kills the ID instruction while the jump moves on
        issue(T_JMP, 1'b1, 5'd2, 5'd0, 5'd31);
        step();
        chk("jmp_ex_ctrl", {1'b0, ex_ctrl}, {1'b0, EX_JMP_L});
        issue(T_SUB, 1'b0, 5'd1, 5'd2, 5'd3);
        flush = 1'b1;
        step();
        chk("flush_ex_valid", {15'd0, ex_valid}, 16'd0);
        chk("flush_ex_ctrl", {1'b0, ex_ctrl}, 16'd0);
        chk("flush_jmp_ma", {15'd0, ma_valid}, 16'd1);
        flush = 1'b0;
        idle();
        step();
        chk("flush_jmp_wb", {13'd0, wb_ctrl}, {13'd0, WB_LINK});
        step();
        step();

        // External stall with a full pipe
        issue(T_JMP, 1'b1, 5'd2, 5'd0, 5'd31);
        step();
        issue(T_LDX, 1'b1, 5'd1, 5'd0, 5'd2);
        step();
        issue(T_SUB, 1'b0, 5'd10, 5'd11, 5'd12);
        step();
        stall_ext = 1'b1;
        flush     = 1'b1;
        issue(T_ADD, 1'b0, 5'd2, 5'd2, 5'd4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ex_ctrl", {1'b0, ex_ctrl}, {1'b0, EX_SUB_R});
            chk("stall_ma_ctrl", {14'd0, ma_ctrl}, {14'd0, MA_LOAD});
            chk("stall_wb_ctrl", {13'd0, wb_ctrl}, {13'd0, WB_LINK});
            chk("stall_valids", {13'd0, ex_valid, ma_valid, wb_valid}, 16'd7);
        end
        stall_ext = 1'b0;
        flush     = 1'b0;
        step();
        chk("resume_ex_ctrl", {1'b0, ex_ctrl}, {1'b0, EX_ADD_R});
        chk("resume_ma_ctrl", {14'd0, ma_ctrl}, 16'd0);
        chk("resume_wb_ctrl", {13'd0, wb_ctrl}, {13'd0, WB_MEM});
        chk("resume_valids", {13'd0, ex_valid, ma_valid, wb_valid}, 16'd7);

        // HLT drains the pipe then halts
        issue(T_HLT, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("pre_hlt_halt_fetch", {15'd0, halt_fetch}, 16'd0);
        step();
        chk("hlt_halt_fetch", {15'd0, halt_fetch}, 16'd1);
        chk("hlt_valids", {13'd0, ex_valid, ma_valid, wb_valid}, 16'd3);
        issue(T_ADD, 1'b0, 5'd1, 5'd2, 5'd3);
        step();
        chk("drain1_valids", {13'd0, ex_valid, ma_valid, wb_valid}, 16'd1);
        chk("drain1_wb_ctrl", {13'd0, wb_ctrl}, {13'd0, WB_ALU});
        step();
        chk("drain2_valids", {13'd0, ex_valid, ma_valid, wb_valid}, 16'd0);
        chk("drain2_halted", {15'd0, halted}, 16'd0);
        step();
        chk("drain3_halted", {15'd0, halted}, 16'd0);
        step();
        chk("halted", {15'd0, halted}, 16'd1);
        chk("halted_fetch", {15'd0, halt_fetch}, 16'd1);
        chk("halted_ignores_id", {15'd0, ex_valid}, 16'd0);
        step();
        chk("halted_sticky", {15'd0, halted}, 16'd1);

        // Reset out of HALTED, then reset in the middle of a drain
        rst = 1'b1;
        idle();
        step();
        chk("rst_halted_clear", {14'd0, halt_fetch, halted}, 16'd0);
        rst = 1'b0;
        issue(T_ADD, 1'b0, 5'd2, 5'd3, 5'd1);
        step();
        issue(T_ADD, 1'b0, 5'd2, 5'd3, 5'd4);
        step();
        issue(T_HLT, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        chk("drain_entered", {15'd0, halt_fetch}, 16'd1);
        rst = 1'b1;
        idle();
        step();
        chk("mid_drain_rst_flags", {14'd0, halt_fetch, halted}, 16'd0);
        chk("mid_drain_rst_valids", {13'd0, ex_valid, ma_valid, wb_valid}, 16'd0);
        rst = 1'b0;
        issue(T_ADD, 1'b0, 5'd2, 5'd3, 5'd1);
        step();
        chk("run_after_rst", {15'd0, ex_valid}, 16'd1);
        chk("run_after_rst_fetch", {15'd0, halt_fetch}, 16'd0);
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
